// File: rtl/dsbpm_tbt_pkg.sv
// Shared state encoding and width helpers for the turn-by-turn magnitude accumulator.
package dsbpm_tbt_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_NEXT  = 2'd2
  } tbt_state_e;

  function automatic int cnt_width(input int spt_max);
    return $clog2(spt_max + 1);
  endfunction

  function automatic int acc_width(input int mag_w, input int spt_max);
    return mag_w + $clog2(spt_max);
  endfunction

endpackage

// File: rtl/dsbpm_tbt_chan_acc.sv
// One channel's turn accumulator: clear/load/add with carry-out overflow detection.
// DSBPM_TBT_ACCUM_SATURATE_EN selects clamping at full scale instead of modulo wrap.
module dsbpm_tbt_chan_acc
  import dsbpm_tbt_pkg::*;
#(
  parameter int MAG_WIDTH = 26,
  parameter int ACC_WIDTH = 33
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 add_i,
  input  logic [MAG_WIDTH-1:0] mag_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 ovf_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   raw_sum;

  // One extra bit so the carry out of the add is the overflow indication.
  assign raw_sum = {1'b0, acc_q} + (ACC_WIDTH+1)'(mag_i);
  assign ovf_o   = add_i & raw_sum[ACC_WIDTH];

`ifdef DSBPM_TBT_ACCUM_SATURATE_EN
  assign sum_o = raw_sum[ACC_WIDTH] ? '1 : raw_sum[ACC_WIDTH-1:0];
`else
  assign sum_o = raw_sum[ACC_WIDTH-1:0];
`endif

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = ACC_WIDTH'(mag_i);
    end else if (add_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dsbpm_tbt_mag_accum.sv
// Turn-by-turn magnitude accumulator: sums each channel over one revolution framed by the turn
// marker and flags marker/config/overflow faults. DSBPM_TBT_ACCUM_SATURATE_EN: clamp sums on overflow.
//   state    | meaning
//   ST_HUNT  | waiting for a valid turn marker
//   ST_ACCUM | summing samples of the current turn
//   ST_NEXT  | turn emitted, next valid sample must carry the marker
module dsbpm_tbt_mag_accum
  import dsbpm_tbt_pkg::*;
#(
  parameter int CHANNEL_COUNT        = 4,
  parameter int MAG_WIDTH            = 26,
  parameter int SAMPLES_PER_TURN_MAX = 100,
  parameter int CNT_WIDTH            = cnt_width(SAMPLES_PER_TURN_MAX),
  parameter int ACC_WIDTH            = acc_width(MAG_WIDTH, SAMPLES_PER_TURN_MAX)
) (
  input  logic                               adcClk,
  input  logic                               adcReset,
  input  logic                               enable,
  input  logic [CNT_WIDTH-1:0]               samplesPerTurn,
  input  logic                               clrErr,
  input  logic                               sampleValid,
  input  logic                               turnMarker,
  input  logic [CHANNEL_COUNT*MAG_WIDTH-1:0] magIn,
  output logic                               tbtValid,
  output logic [CHANNEL_COUNT*ACC_WIDTH-1:0] tbtSum,
  output logic [31:0]                        turnCount,
  output logic                               syncErr,
  output logic                               cfgErr,
  output logic                               ovfErr
);

  localparam logic [CNT_WIDTH-1:0] SPT_MIN = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] SPT_MAX = CNT_WIDTH'(SAMPLES_PER_TURN_MAX);

  tbt_state_e                         state_q, state_d;
  logic [CNT_WIDTH-1:0]               cnt_q, cnt_d, spt_q, spt_d, cnt_inc;
  logic                               tbt_valid_q, tbt_valid_d;
  logic [CHANNEL_COUNT*ACC_WIDTH-1:0] tbt_sum_q, tbt_sum_d, sum_next;
  logic [31:0]                        turn_cnt_q, turn_cnt_d;
  logic                               sync_err_q, sync_err_d;
  logic                               cfg_err_q, cfg_err_d;
  logic                               ovf_err_q, ovf_err_d;
  logic [CHANNEL_COUNT-1:0]           ovf_ch;
  logic                               acc_clear, acc_load, acc_add;
  logic                               turn_start, sync_set, cfg_set, spt_ok;

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_chan
    dsbpm_tbt_chan_acc #(
      .MAG_WIDTH (MAG_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
      .clk_i   (adcClk),
      .rst_i   (adcReset),
      .clear_i (acc_clear),
      .load_i  (acc_load),
      .add_i   (acc_add),
      .mag_i   (magIn[g*MAG_WIDTH +: MAG_WIDTH]),
      .sum_o   (sum_next[g*ACC_WIDTH +: ACC_WIDTH]),
      .ovf_o   (ovf_ch[g])
    );
  end

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);
  assign spt_ok  = (samplesPerTurn >= SPT_MIN) && (samplesPerTurn <= SPT_MAX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    spt_d       = spt_q;
    tbt_valid_d = 1'b0;
    tbt_sum_d   = tbt_sum_q;
    turn_cnt_d  = turn_cnt_q;
    sync_err_d  = sync_err_q;
    cfg_err_d   = cfg_err_q;
    ovf_err_d   = ovf_err_q;
    acc_clear   = 1'b0;
    acc_load    = 1'b0;
    acc_add     = 1'b0;
    turn_start  = 1'b0;
    sync_set    = 1'b0;
    cfg_set     = 1'b0;

    if (!enable) begin
      state_d   = ST_HUNT;
      cnt_d     = '0;
      acc_clear = 1'b1;
    end else begin
      if (sampleValid) begin
        unique case (state_q)
          ST_HUNT: begin
            turn_start = turnMarker;
          end
          ST_ACCUM: begin
            if (turnMarker) begin
              sync_set   = 1'b1;
              turn_start = 1'b1;
            end else begin
              acc_add = 1'b1;
              cnt_d   = cnt_inc;
              if (cnt_inc == spt_q) begin
                state_d     = ST_NEXT;
                tbt_valid_d = 1'b1;
                tbt_sum_d   = sum_next;
                turn_cnt_d  = turn_cnt_q + 32'd1;
              end
            end
          end
          ST_NEXT: begin
            if (turnMarker) begin
              turn_start = 1'b1;
            end else begin
              sync_set = 1'b1;
              state_d  = ST_HUNT;
              cnt_d    = '0;
            end
          end
          default: begin
            state_d = ST_HUNT;
            cnt_d   = '0;
          end
        endcase

        // A rejected turn start discards the marker sample and falls back to hunting.
        if (turn_start) begin
          if (spt_ok) begin
            acc_load = 1'b1;
            cnt_d    = CNT_WIDTH'(1);
            spt_d    = samplesPerTurn;
            state_d  = ST_ACCUM;
          end else begin
            cfg_set = 1'b1;
            cnt_d   = '0;
            state_d = ST_HUNT;
          end
        end
      end

      sync_err_d = (sync_err_q & ~clrErr) | sync_set;
      cfg_err_d  = (cfg_err_q & ~clrErr) | cfg_set;
      ovf_err_d  = (ovf_err_q & ~clrErr) | (|ovf_ch);
    end
  end

  always_ff @(posedge adcClk) begin
    if (adcReset) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      spt_q       <= '0;
      tbt_valid_q <= 1'b0;
      tbt_sum_q   <= '0;
      turn_cnt_q  <= '0;
      sync_err_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      spt_q       <= spt_d;
      tbt_valid_q <= tbt_valid_d;
      tbt_sum_q   <= tbt_sum_d;
      turn_cnt_q  <= turn_cnt_d;
      sync_err_q  <= sync_err_d;
      cfg_err_q   <= cfg_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign tbtValid  = tbt_valid_q;
  assign tbtSum    = tbt_sum_q;
  assign turnCount = turn_cnt_q;
  assign syncErr   = sync_err_q;
  assign cfgErr    = cfg_err_q;
  assign ovfErr    = ovf_err_q;

endmodule

// File: tb/tb_dsbpm_tbt_mag_accum.sv
// Scoreboard bench: two DUT widths (33-bit and 27-bit sums) share one randomized stimulus stream.
module tb_dsbpm_tbt_mag_accum;

  localparam int NCH  = 4;
  localparam int MW   = 26;
  localparam int SMAX = 100;
  localparam int CW   = 7;
  localparam int AW0  = 33;
  localparam int AW1  = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, clr, vld, mk;
  logic [CW-1:0]     spt;
  logic [NCH*MW-1:0] mag;
  logic              tv0, tv1, se0, se1, ce0, ce1, oe0, oe1;
  logic [NCH*AW0-1:0] sum0;
  logic [NCH*AW1-1:0] sum1;
  logic [31:0]       tc0, tc1;

  dsbpm_tbt_mag_accum u_dut (
    .adcClk(clk), .adcReset(rst), .enable(en), .samplesPerTurn(spt), .clrErr(clr),
    .sampleValid(vld), .turnMarker(mk), .magIn(mag), .tbtValid(tv0), .tbtSum(sum0),
    .turnCount(tc0), .syncErr(se0), .cfgErr(ce0), .ovfErr(oe0)
  );

  dsbpm_tbt_mag_accum #(.ACC_WIDTH(AW1)) u_dut_narrow (
    .adcClk(clk), .adcReset(rst), .enable(en), .samplesPerTurn(spt), .clrErr(clr),
    .sampleValid(vld), .turnMarker(mk), .magIn(mag), .tbtValid(tv1), .tbtSum(sum1),
    .turnCount(tc1), .syncErr(se1), .cfgErr(ce1), .ovfErr(oe1)
  );

  typedef struct packed {
    logic [NCH*AW0-1:0] sum;
    logic [31:0]        cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: a turn is a list of accepted samples summed with plain integer arithmetic.
  longint unsigned    acc_m [2][NCH];
  bit                 collecting, just_emitted;
  int                 got, m_spt;
  bit                 m_sync, m_cfg;
  bit                 m_ovf [2];
  logic [31:0]        m_tc;
  logic [NCH*AW0-1:0] m_hold [2];
  logic [NCH*MW-1:0]  pat [SMAX];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  function automatic int aw(input int k);
    return (k == 0) ? AW0 : AW1;
  endfunction

  function automatic longint unsigned lane(input int ch);
    return 64'(mag[ch*MW +: MW]);
  endfunction

  function automatic logic [NCH*AW0-1:0] pack(input int k);
    logic [NCH*AW0-1:0] v;
    v = '0;
    for (int ch = 0; ch < NCH; ch++) v = v | ((NCH*AW0)'(acc_m[k][ch]) << (ch * aw(k)));
    return v;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(1));
  endfunction

  task automatic model_step();
    bit new_sync, new_cfg, start;
    bit new_ovf [2];
    longint unsigned lim, t;
    exp_t e;
    new_sync = 0; new_cfg = 0; start = 0; new_ovf[0] = 0; new_ovf[1] = 0;
    if (rst) begin
      collecting = 0; just_emitted = 0; m_sync = 0; m_cfg = 0;
      m_ovf[0] = 0; m_ovf[1] = 0; m_tc = '0; m_hold[0] = '0; m_hold[1] = '0;
    end else if (!en) begin
      collecting = 0; just_emitted = 0;
    end else begin
      if (vld) begin
        if (collecting) begin
          if (mk) begin
            new_sync = 1; start = 1; collecting = 0;
          end else begin
            for (int k = 0; k < 2; k++) begin
              lim = (64'd1 << aw(k)) - 64'd1;
              for (int ch = 0; ch < NCH; ch++) begin
                t = acc_m[k][ch] + lane(ch);
                if (t > lim) begin
                  new_ovf[k] = 1;
`ifdef DSBPM_TBT_ACCUM_SATURATE_EN
                  acc_m[k][ch] = lim;
`else
                  acc_m[k][ch] = t & lim;
`endif
                end else begin
                  acc_m[k][ch] = t;
                end
              end
            end
            got++;
            if (got == m_spt) begin
              m_tc = m_tc + 32'd1;
              for (int k = 0; k < 2; k++) begin
                m_hold[k] = pack(k);
                e.sum = m_hold[k];
                e.cnt = m_tc;
                if (k == 0) q0.push_back(e); else q1.push_back(e);
              end
              collecting = 0; just_emitted = 1;
            end
          end
        end else if (just_emitted) begin
          just_emitted = 0;
          if (mk) start = 1; else new_sync = 1;
        end else begin
          start = mk;
        end
        if (start) begin
          if (spt >= 2 && spt <= SMAX) begin
            collecting = 1; m_spt = int'(spt); got = 1;
            for (int k = 0; k < 2; k++)
              for (int ch = 0; ch < NCH; ch++) acc_m[k][ch] = lane(ch);
          end else begin
            new_cfg = 1;
          end
        end
      end
      m_sync = (m_sync && !clr) || new_sync;
      m_cfg  = (m_cfg && !clr) || new_cfg;
      for (int k = 0; k < 2; k++) m_ovf[k] = (m_ovf[k] && !clr) || new_ovf[k];
    end
  endtask

  task automatic check_inst(input int k, input logic v, input logic [NCH*AW0-1:0] s,
                            input logic [31:0] tc, input logic [2:0] fl);
    exp_t e;
    bit   have;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (v !== 1'b0 || have) begin
      n_cmp++;
      if (v !== 1'b1 || !have) begin
        n_bad++;
        $display("FAIL strobe[%0d] @%0t: tbtValid=%b expected=%0b", k, $time, v, have);
      end
      if (have) begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        n_cmp++;
        if (s !== e.sum) begin
          n_bad++;
          $display("FAIL tbtSum[%0d] @%0t: got %h expected %h", k, $time, s, e.sum);
        end
        n_cmp++;
        if (tc !== e.cnt) begin
          n_bad++;
          $display("FAIL turnCount_strobe[%0d] @%0t: got %0d expected %0d", k, $time, tc, e.cnt);
        end
      end
    end
    n_cmp++;
    if (s !== m_hold[k]) begin
      n_bad++;
      $display("FAIL held_sum[%0d] @%0t: got %h expected %h", k, $time, s, m_hold[k]);
    end
    n_cmp++;
    if (tc !== m_tc) begin
      n_bad++;
      $display("FAIL turnCount[%0d] @%0t: got %0d expected %0d", k, $time, tc, m_tc);
    end
    n_cmp++;
    if (fl !== {m_sync, m_cfg, m_ovf[k]}) begin
      n_bad++;
      $display("FAIL flags[%0d] @%0t: got sync/cfg/ovf=%b expected %b", k, $time, fl,
               {m_sync, m_cfg, m_ovf[k]});
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check_inst(0, tv0, sum0, tc0, {se0, ce0, oe0});
      check_inst(1, tv1, {{(NCH*(AW0-AW1)){1'b0}}, sum1}, tc1, {se1, ce1, oe1});
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic smp(input bit v, input bit m, input bit c = 1'b0);
    vld = v; mk = m; clr = c;
    step();
    vld = 1'b0; mk = 1'b0; clr = 1'b0;
  endtask

  task automatic set_mag(input int c0, input int c1, input int c2, input int c3);
    mag = {MW'(c3), MW'(c2), MW'(c1), MW'(c0)};
  endtask

  // mode 0: hold current magIn, 1: replay pat[], 2: fresh random per sample
  task automatic turn(input int n, input int duty, input int mode);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) >= duty) smp(1'b0, rb());
      if (mode == 1) mag = pat[i];
      if (mode == 2) for (int ch = 0; ch < NCH; ch++) mag[ch*MW +: MW] = MW'($urandom());
      smp(1'b1, i == 0);
    end
  endtask

  initial begin
    int len;
    rst = 1'b1; en = 1'b0; clr = 1'b0; vld = 1'b0; mk = 1'b0; spt = CW'(4); mag = '0;
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    smp(1'b0, 1'b0);

    // constant magnitudes, four samples per turn
    set_mag(10, 1000, 0, 0);
    repeat (3) turn(4, 100, 0);
    chk("t1_sum_ch0", 64'(sum0[0 +: AW0]), 40);
    chk("t1_sum_ch1", 64'(sum0[AW0 +: AW0]), 4000);
    chk("t1_turncount", 64'(tc0), 3);

    // identical samples with continuous and gapped sampleValid
    spt = CW'(100);
    for (int i = 0; i < SMAX; i++)
      for (int ch = 0; ch < NCH; ch++) pat[i][ch*MW +: MW] = MW'($urandom());
    turn(100, 100, 1);
    turn(100, 50, 1);

    // early marker restarts the turn
    spt = CW'(5);
    set_mag(1, 0, 0, 0);
    smp(1'b1, 1'b1); smp(1'b1, 1'b0); smp(1'b1, 1'b1);
    repeat (4) smp(1'b1, 1'b0);
    chk("t3_sum_from_early_marker", 64'(sum0[0 +: AW0]), 5);
    chk("t3_syncerr", 64'(se0), 1);
    smp(1'b1, 1'b1); smp(1'b1, 1'b0); smp(1'b1, 1'b1, 1'b1);
    chk("t3_clr_vs_new_error", 64'(se0), 1);
    repeat (4) smp(1'b1, 1'b0);
    chk("t3_turncount", 64'(tc0), 7);

    // missing marker after a complete turn
    smp(1'b0, 1'b0, 1'b1);
    chk("t4_syncerr_cleared", 64'(se0), 0);
    smp(1'b1, 1'b0);
    chk("t4_syncerr_missing", 64'(se0), 1);
    repeat (2) smp(1'b1, 1'b0);
    turn(5, 100, 2);
    chk("t4_turncount_continues", 64'(tc0), 8);

    // out-of-range samplesPerTurn and a mid-turn change
    smp(1'b0, 1'b0, 1'b1);
    spt = CW'(1);   smp(1'b1, 1'b1);
    chk("t5_cfgerr_spt1", 64'(ce0), 1);
    smp(1'b0, 1'b0, 1'b1);
    spt = CW'(101); smp(1'b1, 1'b1);
    chk("t5_cfgerr_spt101", 64'(ce0), 1);
    spt = CW'(10);
    smp(1'b1, 1'b1);
    spt = CW'(50);
    repeat (9) smp(1'b1, 1'b0);
    chk("t5_old_spt_used", 64'(tc0), 9);

    // full-scale magnitudes: only the narrow instance overflows
    smp(1'b0, 1'b0, 1'b1);
    spt = CW'(100);
    mag = '1;
    turn(100, 100, 0);
    chk("t6_no_ovf_wide", 64'(oe0), 0);
    chk("t6_ovf_narrow", 64'(oe1), 1);
    chk("t6_sum_wide", 64'(sum0[0 +: AW0]), 64'd6710886300);
`ifdef DSBPM_TBT_ACCUM_SATURATE_EN
    chk("t6_sum_narrow", 64'(sum1[0 +: AW1]), (64'd1 << AW1) - 64'd1);
`else
    chk("t6_sum_narrow", 64'(sum1[0 +: AW1]), (64'd1 << AW1) - 64'd100);
`endif
    smp(1'b1, 1'b1); smp(1'b1, 1'b0); smp(1'b1, 1'b0);
    rst = 1'b1;
    smp(1'b1, 1'b0);
    chk("t6_reset_sum", 64'(sum0[0 +: AW0]), 0);
    chk("t6_reset_turncount", 64'(tc0), 0);
    chk("t6_reset_flags", 64'({se0, ce0, oe0, tv0}), 0);
    rst = 1'b0;

    // randomized soak
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(99) < 8)
        spt = rb() ? CW'($urandom_range(1)) : CW'($urandom_range(127, 101));
      else
        spt = CW'($urandom_range(12, 2));
      if ($urandom_range(99) >= 95) begin
        en = 1'b0;
        repeat ($urandom_range(3, 1)) smp(rb(), rb());
        en = 1'b1;
      end
      if (spt >= 2 && spt <= SMAX) len = int'(spt) + int'($urandom_range(2)) - 1;
      else len = int'($urandom_range(4, 1));
      turn(len, int'($urandom_range(100, 40)), 2);
      if ($urandom_range(9) == 0) smp(1'b0, 1'b0, 1'b1);
      if ($urandom_range(5) == 0) smp(1'b1, 1'b0);
    end

    repeat (3) smp(1'b0, 1'b0);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending strobes %0d/%0d expected 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
